// File: rtl/imem_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl_if
// Bundles the two buses of the instruction fetch controller:
//   - ID handshake : if_valid / if_ready / if_instr / if_pc
//   - memory port  : mem_read / mem_addr / mem_rdata
// Modports:
//   master : the fetch controller (drives the instruction stream and memory
//            requests, receives if_ready and mem_rdata)
//   slave  : the ID stage plus the instruction memory bank
// ---------------------------------------------------------------------------
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_valid, if_instr, if_pc, mem_read, mem_addr,
        input  if_ready, mem_rdata
    );

    modport slave (
        input  if_valid, if_instr, if_pc, mem_read, mem_addr,
        output if_ready, mem_rdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
// IF-stage fetch sequencer. Owns the PC, issues reads to a fixed-latency
// instruction memory, tracks in-flight reads with a tag shift register,
// buffers returned words in a small FIFO and hands them to ID over a
// valid/ready handshake. A redirect from EX flushes buffered and in-flight
// fetches and restarts at the new (word aligned) PC.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   en           : fetch enable (stops new issues only)
//   redirect     : one-cycle flush/restart pulse, redirect_pc is the target
//   bus (master) : ID handshake and instruction memory read port
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
    parameter int                ADDR_W     = 8,
    parameter int                DATA_W     = 32,
    parameter int                RD_LAT     = 1,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    imem_fetch_ctrl_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

    logic [ADDR_W-1:0] pc;
    logic [RD_LAT-1:0] tag_valid;
    logic [ADDR_W-1:0] tag_pc [RD_LAT];

    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              issue;
    logic              push;
    logic              pop;
    logic              credit;
    logic [CRD_W-1:0]  inflight;
    logic [CRD_W-1:0]  occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CRD_W'(tag_valid[i]);
        end
    end

    // Slots already claimed: buffered words plus reads still in the memory
    // pipe, minus the word ID takes this cycle. Issuing only below depth
    // guarantees every returning word has a FIFO slot.
    assign pop       = (count != '0) && bus.if_ready;
    assign occupancy = CRD_W'(count) + inflight - CRD_W'(pop);
    assign credit    = occupancy < CRD_W'(FIFO_DEPTH);

    // rst_n gates the strobe so no read is requested while held in reset.
    assign issue = rst_n && en && !redirect && credit;

    // A redirect discards the word returning on the same edge.
    assign push = tag_valid[RD_LAT-1] && !redirect;

    assign bus.mem_read = issue;
    assign bus.mem_addr = pc;
    assign bus.if_valid = (count != '0);
    assign bus.if_instr = fifo_instr[rd_ptr];
    assign bus.if_pc    = fifo_pc[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc & ~ADDR_W'(3);
        end else if (issue) begin
            pc <= pc + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
        end else if (redirect) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
    end

    // Tag PCs are only meaningful alongside their valid bit.
    always_ff @(posedge clk) begin
        tag_pc[0] <= pc;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_pc[i] <= tag_pc[i-1];
        end
    end

    // NOTE: the FIFO storage is reset because its head drives if_instr/if_pc
    // directly, and those outputs must read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
            end
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                fifo_instr[wr_ptr] <= bus.mem_rdata;
                fifo_pc[wr_ptr]    <= tag_pc[RD_LAT-1];
                wr_ptr             <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    fifo_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == CNT_W'(FIFO_DEPTH)))
    );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_ctrl
// Directed bench for imem_fetch_ctrl. Two instances:
//   dut_a : RD_LAT=1, FIFO_DEPTH=2, RESET_PC=00 (stream, backpressure,
//           redirect, wrap-around, enable toggle)
//   dut_b : RD_LAT=3, FIFO_DEPTH=4, RESET_PC=40 (latency, async reset
//           mid-stream)
// Each instance has a memory model whose data word encodes its address.
// Registered outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_imem_fetch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n_a, en_a, redirect_a;
    logic [7:0] redirect_pc_a;
    logic       rst_n_b, en_b, redirect_b;
    logic [7:0] redirect_pc_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
    imem_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus_b ();

    imem_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(32), .RD_LAT(1), .FIFO_DEPTH(2), .RESET_PC(8'h00)
    ) dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .redirect(redirect_a),
        .redirect_pc(redirect_pc_a), .bus(bus_a.master)
    );

    imem_fetch_ctrl #(
        .ADDR_W(8), .DATA_W(32), .RD_LAT(3), .FIFO_DEPTH(4), .RESET_PC(8'h40)
    ) dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .redirect(redirect_b),
        .redirect_pc(redirect_pc_b), .bus(bus_b.master)
    );

    function automatic logic [31:0] instr_of(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    // Memory models: address captured on every edge, data presented RD_LAT
    // edges after the issue edge.
    logic [7:0] pa0 = '0;
    logic [7:0] pb0 = '0, pb1 = '0, pb2 = '0;
    always @(posedge clk) begin
        pa0 <= bus_a.mem_addr;
        pb0 <= bus_b.mem_addr;
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign bus_a.mem_rdata = instr_of(pa0);
    assign bus_b.mem_rdata = instr_of(pb2);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic head_a(input string tag, input logic [7:0] pc);
        check({tag, " valid"}, 32'(bus_a.if_valid), 32'd1);
        check({tag, " pc"},    32'(bus_a.if_pc), 32'(pc));
        check({tag, " instr"}, bus_a.if_instr, instr_of(pc));
    endtask

    task automatic head_b(input string tag, input logic [7:0] pc);
        check({tag, " valid"}, 32'(bus_b.if_valid), 32'd1);
        check({tag, " pc"},    32'(bus_b.if_pc), 32'(pc));
        check({tag, " instr"}, bus_b.if_instr, instr_of(pc));
    endtask

    task automatic reset_state_b(input string tag);
        check({tag, " valid"}, 32'(bus_b.if_valid), 32'd0);
        check({tag, " instr"}, bus_b.if_instr, 32'd0);
        check({tag, " pc"},    32'(bus_b.if_pc), 32'd0);
        check({tag, " read"},  32'(bus_b.mem_read), 32'd0);
        check({tag, " addr"},  32'(bus_b.mem_addr), 32'h40);
    endtask

    // Release dut_b reset and walk through the RD_LAT=3 fill: issues from
    // cycle 1, first valid word in cycle 5, then one word per cycle.
    task automatic start_b(input string tag);
        logic [7:0] exp;
        rst_n_b = 1'b1;
        #1;
        check({tag, " c1 read"}, 32'(bus_b.mem_read), 32'd1);
        check({tag, " c1 addr"}, 32'(bus_b.mem_addr), 32'h40);
        check({tag, " c1 valid"}, 32'(bus_b.if_valid), 32'd0);
        tick();
        check({tag, " c2 addr"}, 32'(bus_b.mem_addr), 32'h44);
        check({tag, " c2 valid"}, 32'(bus_b.if_valid), 32'd0);
        tick();
        check({tag, " c3 valid"}, 32'(bus_b.if_valid), 32'd0);
        tick();
        check({tag, " c4 addr"}, 32'(bus_b.mem_addr), 32'h4C);
        check({tag, " c4 valid"}, 32'(bus_b.if_valid), 32'd0);
        tick();
        exp = 8'h40;
        for (int i = 0; i < 4; i++) begin
            head_b({tag, " stream"}, exp);
            exp = exp + 8'h04;
            tick();
        end
    endtask

    logic [7:0] exp_pc;

    initial begin
        rst_n_a = 1'b0; en_a = 1'b1; redirect_a = 1'b0; redirect_pc_a = '0;
        rst_n_b = 1'b0; en_b = 1'b1; redirect_b = 1'b0; redirect_pc_b = '0;
        bus_a.if_ready = 1'b1;
        bus_b.if_ready = 1'b1;
        tick();
        tick();

        // ---- dut_a reset state
        check("a rst valid", 32'(bus_a.if_valid), 32'd0);
        check("a rst instr", bus_a.if_instr, 32'd0);
        check("a rst pc",    32'(bus_a.if_pc), 32'd0);
        check("a rst read",  32'(bus_a.mem_read), 32'd0);
        check("a rst addr",  32'(bus_a.mem_addr), 32'h00);

        // ---- release: issue 00 in c1, first valid in c3
        rst_n_a = 1'b1;
        #1;
        check("a c1 read", 32'(bus_a.mem_read), 32'd1);
        check("a c1 addr", 32'(bus_a.mem_addr), 32'h00);
        check("a c1 valid", 32'(bus_a.if_valid), 32'd0);
        tick();
        check("a c2 addr", 32'(bus_a.mem_addr), 32'h04);
        check("a c2 read", 32'(bus_a.mem_read), 32'd1);
        check("a c2 valid", 32'(bus_a.if_valid), 32'd0);
        tick();
        exp_pc = 8'h00;
        for (int i = 0; i < 4; i++) begin
            head_a("a stream", exp_pc);
            check("a stream addr", 32'(bus_a.mem_addr), 32'(exp_pc + 8'h08));
            check("a stream read", 32'(bus_a.mem_read), 32'd1);
            exp_pc = exp_pc + 8'h04;
            tick();
        end

        // ---- backpressure: 5 stalled cycles, FIFO fills, head held
        bus_a.if_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            head_a("a stall", 8'h10);
            check("a stall read", 32'(bus_a.mem_read), 32'd0);
            tick();
        end
        bus_a.if_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            head_a("a resume", exp_pc);
            exp_pc = exp_pc + 8'h04;
            tick();
        end

        // ---- redirect to 25 with one word buffered and one in flight
        redirect_a = 1'b1;
        redirect_pc_a = 8'h25;
        #1;
        check("a redir read", 32'(bus_a.mem_read), 32'd0);
        head_a("a redir pop", 8'h20);
        tick();
        redirect_a = 1'b0;
        #1;
        check("a redir+1 valid", 32'(bus_a.if_valid), 32'd0);
        check("a redir+1 read", 32'(bus_a.mem_read), 32'd1);
        check("a redir+1 addr", 32'(bus_a.mem_addr), 32'h24);
        tick();
        check("a redir+2 valid", 32'(bus_a.if_valid), 32'd0);
        tick();
        exp_pc = 8'h24;
        for (int i = 0; i < 3; i++) begin
            head_a("a redir stream", exp_pc);
            exp_pc = exp_pc + 8'h04;
            tick();
        end

        // ---- wrap-around from F8
        redirect_a = 1'b1;
        redirect_pc_a = 8'hF8;
        #1;
        check("a wrap redir read", 32'(bus_a.mem_read), 32'd0);
        head_a("a wrap redir pop", 8'h30);
        tick();
        redirect_a = 1'b0;
        #1;
        check("a wrap addr F8", 32'(bus_a.mem_addr), 32'hF8);
        check("a wrap valid0", 32'(bus_a.if_valid), 32'd0);
        tick();
        check("a wrap addr FC", 32'(bus_a.mem_addr), 32'hFC);
        check("a wrap valid1", 32'(bus_a.if_valid), 32'd0);
        tick();
        check("a wrap addr 00", 32'(bus_a.mem_addr), 32'h00);
        exp_pc = 8'hF8;
        for (int i = 0; i < 4; i++) begin
            head_a("a wrap stream", exp_pc);
            exp_pc = exp_pc + 8'h04;
            tick();
        end

        // ---- en low for 4 cycles: in-flight word lands, FIFO drains
        en_a = 1'b0;
        #1;
        check("a en0 c1 read", 32'(bus_a.mem_read), 32'd0);
        head_a("a en0 c1", 8'h08);
        tick();
        check("a en0 c2 read", 32'(bus_a.mem_read), 32'd0);
        head_a("a en0 c2", 8'h0C);
        tick();
        for (int i = 0; i < 2; i++) begin
            check("a en0 idle valid", 32'(bus_a.if_valid), 32'd0);
            check("a en0 idle read", 32'(bus_a.mem_read), 32'd0);
            check("a en0 idle addr", 32'(bus_a.mem_addr), 32'h10);
            tick();
        end
        en_a = 1'b1;
        #1;
        check("a en1 read", 32'(bus_a.mem_read), 32'd1);
        check("a en1 addr", 32'(bus_a.mem_addr), 32'h10);
        check("a en1 valid", 32'(bus_a.if_valid), 32'd0);
        tick();
        check("a en1+1 valid", 32'(bus_a.if_valid), 32'd0);
        tick();
        head_a("a en1 resume", 8'h10);
        tick();
        head_a("a en1 resume", 8'h14);

        // ---- dut_b: RD_LAT=3, RESET_PC=40
        tick();
        reset_state_b("b rst");
        start_b("b");
        head_b("b pre-reset", 8'h50);

        // async reset between edges: outputs drop without a clock edge
        #2;
        rst_n_b = 1'b0;
        #1;
        reset_state_b("b async rst");
        tick();
        tick();
        reset_state_b("b held rst");
        start_b("b restart");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
